ntt_vec_seq: RTL and testbench
==============================

NTT_VEC_SEQ -- requirements
Module: ntt_vec_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, vector-memory address width.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  launch request, sampled in IDLE only.
REQ-005 SHALL have port opcode  input  2  0=ADD, 1=MULT, 2/3 illegal.
REQ-006 SHALL have port len  input  ADDR_W+1  element count, 0..2^ADDR_W.
REQ-007 SHALL have ports base_a, base_b, base_r  input  ADDR_W each  operand A, operand B and result base addresses.
REQ-008 SHALL have port q_in  input  64  modulus.
REQ-009 SHALL have ports rd_en  output  1, and rd_addr_a, rd_addr_b  output  ADDR_W  synchronous-read request to operand memories.
REQ-010 SHALL have ports rd_data_a, rd_data_b  input  64  read data, valid the cycle after rd_en.
REQ-011 SHALL have ports au_opcode  output  2, au_op_a, au_op_b, au_q  output  64  arithmetic-unit operands; arithmetic-unit result is registered, 1-cycle latency.
REQ-012 SHALL have port au_res  input  64  arithmetic-unit result.
REQ-013 SHALL have ports wr_en  output  1, wr_addr  output  ADDR_W, wr_data  output  64  result-memory write.
REQ-014 SHALL have ports busy  output  1, done  output  1 (single-cycle pulse), err  output  1 (sticky illegal-opcode flag).

Function
REQ-015 SHALL implement states IDLE, ISSUE, DRAIN, FINISH; IDLE->ISSUE on start with legal opcode and len>0; ISSUE->DRAIN after len issues; DRAIN->FINISH when pipeline is empty; FINISH->IDLE unconditionally.
REQ-016 SHALL latch opcode, len, base addresses and q_in on the accepting start; later input changes have no effect until the next start.
REQ-017 SHALL in ISSUE assert rd_en one cycle per element k=0..len-1 with rd_addr_a=base_a+k and rd_addr_b=base_b+k, modulo 2^ADDR_W, without gaps.
REQ-018 SHALL drive au_op_a=rd_data_a, au_op_b=rd_data_b, au_opcode=latched opcode, au_q=latched q_in.
REQ-019 SHALL assert wr_en exactly 2 cycles after the matching rd_en, with wr_data=au_res and wr_addr=base_r+k, modulo 2^ADDR_W.
REQ-020 SHALL track in-flight elements with a 2-stage valid pipeline; DRAIN lasts exactly 2 cycles.
REQ-021 SHALL assert busy in every state except IDLE; start while busy is ignored.
REQ-022 SHALL pulse done for 1 cycle in FINISH; sequence latency is first rd_en to done = len+2 cycles.
REQ-023 SHALL, on start with len=0, go IDLE->FINISH with no rd_en/wr_en and pulse done.
REQ-024 SHALL, on start with opcode 2 or 3, set err, issue no reads/writes, go to FINISH and pulse done; err clears on the next accepted legal start.

Reset
REQ-025 SHALL, on rst (including mid-operation), immediately go to IDLE and clear busy, done, err, rd_en, wr_en, the valid pipeline and all counters; address/data outputs SHALL be 0.
REQ-026 SHALL drop any partial vector on reset with no further writes after rst is asserted.

Configuration
REQ-027 SHALL, when NTT_SEQ_PERF_EN is defined, provide output perf_cycles (32 bits) counting busy cycles of the last sequence, cleared on accepted start and on rst, saturating at 2^32-1.
REQ-028 SHALL, when NTT_SEQ_PERF_EN is undefined, omit perf_cycles and its counter; all other behaviour is identical.

Verification
REQ-029 SHALL cover ADD: q=17, len=4, A={1,5,16,9}, B={2,14,3,8} -> writes {3,2,2,0} at base_r..base_r+3, done at first rd_en+6.
REQ-030 SHALL cover MULT: q=97, len=2, A={10,96}, B={10,96} -> writes {3,1}.
REQ-031 SHALL cover wrap: ADDR_W=10, base_r=1022, len=4 -> wr_addr 1022,1023,0,1.
REQ-032 SHALL cover boundaries: len=0 -> done 1 cycle later, no rd_en/wr_en; opcode=3 -> err=1, done, no writes; a following legal start clears err.
REQ-033 SHALL cover reset mid-run: rst at element 3 of len=8 -> wr_en=0 immediately, busy=0, no writes afterwards; a subsequent start runs normally.
REQ-034 SHALL cover start while busy -> ignored and latched config unchanged; with NTT_SEQ_PERF_EN, len=4 -> perf_cycles=8.

Source files
------------

// File: rtl/ntt_vec_seq.sv
// Vector sequencer for the NTT arithmetic unit: streams len element pairs from the operand
// memories through an external 1-cycle arithmetic unit and writes the results back.
// Optional feature: define NTT_SEQ_PERF_EN to add the perf_cycles busy-cycle counter.
module ntt_vec_seq #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        opcode,
    input  logic [ADDR_W:0]   len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_r,
    input  logic [63:0]       q_in,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [63:0]       rd_data_a,
    input  logic [63:0]       rd_data_b,
    output logic [1:0]        au_opcode,
    output logic [63:0]       au_op_a,
    output logic [63:0]       au_op_b,
    output logic [63:0]       au_q,
    input  logic [63:0]       au_res,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    output logic              busy,
    output logic              done,
`ifdef NTT_SEQ_PERF_EN
    output logic [31:0]       perf_cycles,
`endif
    output logic              err
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

    state_e            state_q;
    logic [1:0]        op_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt_q;   // elements issued so far, including the one on the bus
    logic [63:0]       q_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_a_q;
    logic [ADDR_W-1:0] rd_addr_b_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic              v1_q;    // read data returning this cycle
    logic              v2_q;    // arithmetic result available this cycle
    logic              done_q;
    logic              err_q;

    // Control FSM, address generation and the 2-stage in-flight valid pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            q_q         <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            wr_addr_q   <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            v1_q   <= rd_en_q;
            v2_q   <= v1_q;
            done_q <= 1'b0;
            if (v2_q) begin
                wr_addr_q <= wr_addr_q + 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q        <= opcode;
                        len_q       <= len;
                        q_q         <= q_in;
                        rd_addr_a_q <= base_a;
                        rd_addr_b_q <= base_b;
                        wr_addr_q   <= base_r;
                        cnt_q       <= '0;
                        if (opcode[1]) begin
                            // Opcodes 2/3: flag and finish without touching memory.
                            err_q   <= 1'b1;
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b0;
                            if (len == '0) begin
                                state_q <= StFinish;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= StIssue;
                                rd_en_q <= 1'b1;
                                cnt_q   <= {{ADDR_W{1'b0}}, 1'b1};
                            end
                        end
                    end
                end
                StIssue: begin
                    if (cnt_q == len_q) begin
                        rd_en_q <= 1'b0;
                        state_q <= StDrain;
                    end else begin
                        rd_addr_a_q <= rd_addr_a_q + 1'b1;
                        rd_addr_b_q <= rd_addr_b_q + 1'b1;
                        cnt_q       <= cnt_q + 1'b1;
                    end
                end
                StDrain: begin
                    // Last read has left stage 1; its write happens this cycle.
                    if (!v1_q) begin
                        state_q <= StFinish;
                        done_q  <= 1'b1;
                    end
                end
                StFinish: state_q <= StIdle;
                default:  state_q <= StIdle;
            endcase
        end
    end

`ifdef NTT_SEQ_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter: the accepting cycle counts as the first, then every non-idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (state_q == StIdle && start) begin
            perf_q <= 32'd1;
        end else if (state_q != StIdle && perf_q != '1) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign au_opcode = op_q;
    assign au_q      = q_q;
    // Data outputs are forced to zero outside their valid slot so reset leaves them at 0.
    assign au_op_a   = v1_q ? rd_data_a : '0;
    assign au_op_b   = v1_q ? rd_data_b : '0;
    assign wr_en     = v2_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = v2_q ? au_res : '0;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ntt_vec_seq.sv
// Self-checking bench for ntt_vec_seq: memory + arithmetic-unit models and a write scoreboard.
module tb_ntt_vec_seq;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    opcode = 2'd0;
    logic [AW:0]   len = '0;
    logic [AW-1:0] base_a = '0;
    logic [AW-1:0] base_b = '0;
    logic [AW-1:0] base_r = '0;
    logic [63:0]   q_in = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic [63:0]   rd_data_a = '0;
    logic [63:0]   rd_data_b = '0;
    logic [1:0]    au_opcode;
    logic [63:0]   au_op_a;
    logic [63:0]   au_op_b;
    logic [63:0]   au_q;
    logic [63:0]   au_res = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic          busy;
    logic          done;
    logic          err;
`ifdef NTT_SEQ_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    ntt_vec_seq #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .len       (len),
        .base_a    (base_a),
        .base_b    (base_b),
        .base_r    (base_r),
        .q_in      (q_in),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .au_opcode (au_opcode),
        .au_op_a   (au_op_a),
        .au_op_b   (au_op_b),
        .au_q      (au_q),
        .au_res    (au_res),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done),
`ifdef NTT_SEQ_PERF_EN
        .perf_cycles (perf_cycles),
`endif
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [63:0]   data;
    } wr_t;

    logic [63:0] mem_a [1024];
    logic [63:0] mem_b [1024];
    wr_t         exp_q [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int first_rd = -1;
    int done_cyc = -1;
    bit sb_on = 1'b1;

    function automatic logic [63:0] au_model(logic [1:0] op, logic [63:0] a, logic [63:0] b,
                                             logic [63:0] q);
        logic [127:0] t;
        if (q == 64'd0) return 64'd0;
        case (op)
            2'd0:    t = {64'd0, a} + {64'd0, b};
            2'd1:    t = {64'd0, a} * {64'd0, b};
            default: return 64'd0;
        endcase
        return 64'(t % {64'd0, q});
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read operand memories.
    always @(posedge clk) begin
        if (rd_en) begin
            rd_data_a <= mem_a[rd_addr_a];
            rd_data_b <= mem_b[rd_addr_b];
        end
    end

    // Registered arithmetic unit.
    always @(posedge clk) au_res <= au_model(au_opcode, au_op_a, au_op_b, au_q);

    // Output monitor and write scoreboard.
    always @(negedge clk) begin : mon
        wr_t e;
        if (rd_en) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (wr_en) begin
            wr_cnt++;
            if (sb_on) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_write got addr=%0d data=%0d required no write",
                             wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if (wr_addr !== e.addr || wr_data !== e.data) begin
                        failures++;
                        $display("FAIL sb_write got addr=%0d data=%0d required addr=%0d data=%0d",
                                 wr_addr, wr_data, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic clear_stats();
        rd_cnt   = 0;
        wr_cnt   = 0;
        done_cnt = 0;
        first_rd = -1;
        done_cyc = -1;
    endtask

    task automatic push_exp(input int addr, input logic [63:0] data);
        wr_t e;
        e.addr = AW'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Drives one sequence and waits (bounded) for done; optionally pokes start while busy.
    task automatic run_vec(input logic [1:0] op, input int n, input int ba, input int bb,
                           input int br, input logic [63:0] q, input bit poke,
                           output int start_cyc);
        clear_stats();
        @(negedge clk);
        opcode = op;
        len    = (AW+1)'(n);
        base_a = AW'(ba);
        base_b = AW'(bb);
        base_r = AW'(br);
        q_in   = q;
        start  = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            opcode = 2'd1;
            len    = (AW+1)'(2);
            base_a = AW'(700);
            base_b = AW'(800);
            base_r = AW'(900);
            q_in   = 64'd5;
            start  = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
        if (done_cnt == 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout got no done required done within 3000 cycles");
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, rd_en, wr_en} !== 5'b0 || rd_addr_a !== '0 || wr_addr !== '0 ||
            wr_data !== '0 || au_op_a !== '0 || au_q !== '0) begin
            failures++;
            $display("FAIL reset_state got busy=%b done=%b err=%b rd_en=%b wr_en=%b required all 0",
                     busy, done, err, rd_en, wr_en);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        int sc;
        logic [63:0] a[4] = '{1, 5, 16, 9};
        logic [63:0] b[4] = '{2, 14, 3, 8};
        logic [63:0] r[4] = '{3, 2, 2, 0};
        for (int k = 0; k < 4; k++) begin
            mem_a[k]       = a[k];
            mem_b[100 + k] = b[k];
            push_exp(200 + k, r[k]);
        end
        run_vec(2'd0, 4, 0, 100, 200, 64'd17, 1'b0, sc);
        checks++;
        if (exp_q.size() !== 0 || wr_cnt !== 4 || rd_cnt !== 4) begin
            failures++;
            $display("FAIL add_counts got left=%0d wr=%0d rd=%0d required 0/4/4",
                     exp_q.size(), wr_cnt, rd_cnt);
        end
        checks++;
        if (first_rd !== sc + 1) begin
            failures++;
            $display("FAIL add_first_rd got %0d required %0d", first_rd, sc + 1);
        end
        checks++;
        if (done_cyc !== first_rd + 6) begin
            failures++;
            $display("FAIL add_done_latency got %0d required %0d", done_cyc - first_rd, 6);
        end
    endtask

    task automatic test_mult();
        int sc;
        mem_a[10] = 64'd10; mem_a[11] = 64'd96;
        mem_b[20] = 64'd10; mem_b[21] = 64'd96;
        push_exp(300, 64'd3);
        push_exp(301, 64'd1);
        run_vec(2'd1, 2, 10, 20, 300, 64'd97, 1'b0, sc);
        checks++;
        if (exp_q.size() !== 0 || wr_cnt !== 2 || done_cyc !== sc + 5) begin
            failures++;
            $display("FAIL mult got left=%0d wr=%0d done_at=%0d required 0/2/%0d",
                     exp_q.size(), wr_cnt, done_cyc, sc + 5);
        end
    endtask

    task automatic test_wrap();
        int sc;
        for (int k = 0; k < 4; k++) begin
            mem_a[(1022 + k) % 1024] = 64'($urandom_range(0, 999));
            mem_b[(1020 + k) % 1024] = 64'($urandom_range(0, 999));
            push_exp((1022 + k) % 1024, au_model(2'd0, mem_a[(1022 + k) % 1024],
                                                 mem_b[(1020 + k) % 1024], 64'd1000));
        end
        run_vec(2'd0, 4, 1022, 1020, 1022, 64'd1000, 1'b0, sc);
        checks++;
        if (exp_q.size() !== 0 || wr_cnt !== 4) begin
            failures++;
            $display("FAIL wrap got left=%0d wr=%0d required 0/4", exp_q.size(), wr_cnt);
        end
    endtask

    task automatic test_len0();
        int sc;
        run_vec(2'd0, 0, 5, 6, 7, 64'd17, 1'b0, sc);
        checks++;
        if (done_cyc !== sc + 1 || rd_cnt !== 0 || wr_cnt !== 0 || done_cnt !== 1) begin
            failures++;
            $display("FAIL len0 got done_at=%0d rd=%0d wr=%0d done_n=%0d required %0d/0/0/1",
                     done_cyc, rd_cnt, wr_cnt, done_cnt, sc + 1);
        end
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL len0_idle got busy=%b err=%b required 0/0", busy, err);
        end
    endtask

    task automatic test_illegal();
        int sc;
        run_vec(2'd3, 4, 0, 100, 400, 64'd17, 1'b0, sc);
        checks++;
        if (err !== 1'b1 || done_cnt !== 1 || rd_cnt !== 0 || wr_cnt !== 0) begin
            failures++;
            $display("FAIL illegal got err=%b done_n=%0d rd=%0d wr=%0d required 1/1/0/0",
                     err, done_cnt, rd_cnt, wr_cnt);
        end
        mem_a[30] = 64'd4;
        mem_b[31] = 64'd6;
        push_exp(410, 64'd10);
        run_vec(2'd0, 1, 30, 31, 410, 64'd17, 1'b0, sc);
        checks++;
        if (err !== 1'b0 || exp_q.size() !== 0 || wr_cnt !== 1) begin
            failures++;
            $display("FAIL err_clear got err=%b left=%0d wr=%0d required 0/0/1",
                     err, exp_q.size(), wr_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int sc;
        bit hit = 1'b0;
        sb_on = 1'b0;
        clear_stats();
        @(negedge clk);
        opcode = 2'd0;
        len    = (AW+1)'(8);
        base_a = AW'(50);
        base_b = AW'(60);
        base_r = AW'(70);
        q_in   = 64'd17;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            if (rd_en && rd_addr_a == AW'(53)) hit = 1'b1;
            else @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (!hit || wr_en !== 1'b0 || busy !== 1'b0 || rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got hit=%b wr_en=%b busy=%b rd_en=%b required 1/0/0/0",
                     hit, wr_en, busy, rd_en);
        end
        wr_cnt = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (wr_cnt !== 0) begin
            failures++;
            $display("FAIL reset_mid_writes got %0d required 0", wr_cnt);
        end
        sb_on = 1'b1;
        mem_a[80] = 64'd7; mem_a[81] = 64'd8;
        mem_b[90] = 64'd9; mem_b[91] = 64'd10;
        push_exp(95, 64'd16);
        push_exp(96, 64'd1);
        run_vec(2'd0, 2, 80, 90, 95, 64'd17, 1'b0, sc);
        checks++;
        if (exp_q.size() !== 0 || wr_cnt !== 2 || done_cyc !== sc + 5) begin
            failures++;
            $display("FAIL after_reset got left=%0d wr=%0d done_at=%0d required 0/2/%0d",
                     exp_q.size(), wr_cnt, done_cyc, sc + 5);
        end
    endtask

    task automatic test_back_to_back_busy_start();
        int sc;
        for (int k = 0; k < 4; k++) begin
            mem_a[40 + k] = 64'($urandom_range(0, 22));
            mem_b[50 + k] = 64'($urandom_range(0, 22));
            push_exp(60 + k, au_model(2'd0, mem_a[40 + k], mem_b[50 + k], 64'd23));
        end
        run_vec(2'd0, 4, 40, 50, 60, 64'd23, 1'b1, sc);
        checks++;
        if (exp_q.size() !== 0 || wr_cnt !== 4 || rd_cnt !== 4 || done_cnt !== 1) begin
            failures++;
            $display("FAIL busy_start got left=%0d wr=%0d rd=%0d done_n=%0d required 0/4/4/1",
                     exp_q.size(), wr_cnt, rd_cnt, done_cnt);
        end
        checks++;
        if (au_q !== 64'd23 || au_opcode !== 2'd0) begin
            failures++;
            $display("FAIL busy_start_cfg got q=%0d op=%0d required 23/0", au_q, au_opcode);
        end
`ifdef NTT_SEQ_PERF_EN
        checks++;
        if (perf_cycles !== 32'd8) begin
            failures++;
            $display("FAIL perf_cycles got %0d required 8", perf_cycles);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        test_reset();
        test_add();
        test_mult();
        test_wrap();
        test_len0();
        test_illegal();
        test_reset_mid();
        test_back_to_back_busy_start();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
